axi4_ax_sender_q: RTL and testbench
===================================

Name: axi4_ax_sender_q

Overview:
- Parametrised address-channel sender for the RAB, usable for either AR or AW.
- Forwards an AXI4 address beat to the master side only after the translation logic has issued an accept or drop decision for it.
- Decisions may arrive ahead of the address, are queued in order, and are matched one-to-one to slave-side address beats.
- Adds a registered master output slice, an outstanding-transaction limiter and drop reporting toward the error-response generator.

Parameters:
- C_AXI_ID_WIDTH, 4, ID width.
- C_AXI_USER_WIDTH, 4, user width.
- C_ADDR_WIDTH, 32, address width.
- C_DEC_DEPTH, 4, decision queue depth; power of 2, at least 2.
- C_MAX_OUTSTANDING, 8, maximum accepted-but-uncompleted transactions; at least 1.

Ports:
- axi4_aclk  in  1  clock; all logic on rising edge.
- axi4_arst  in  1  reset, synchronous, active-high.
- trans_accept  in  1  accept decision for the next unmatched address beat.
- trans_drop  in  1  drop decision; drop wins if both are high.
- dec_ready  out  1  decision queue not full; a decision pushes only when dec_ready=1.
- trans_done  in  1  one pulse per completed response of a forwarded transaction.
- s_axi4_axid/axaddr/axlen/axsize/axburst/axlock/axprot/axcache/axuser  in  ID/ADDR/8/3/2/1/3/4/USER  slave-side address fields.
- s_axi4_axvalid  in  1  slave-side valid.
- s_axi4_axready  out  1  slave-side ready.
- m_axi4_axid/axaddr/axlen/axsize/axburst/axlock/axprot/axcache/axuser  out  same widths  registered master-side fields.
- m_axi4_axvalid  out  1  master-side valid, registered.
- m_axi4_axready  in  1  master-side ready.
- trans_sent  out  1  m_axi4_axvalid & m_axi4_axready.
- trans_dropped  out  1  registered one-cycle pulse, one per dropped beat.
- drop_id  out  C_AXI_ID_WIDTH  ID of the dropped beat; valid with trans_dropped.
- drop_len  out  8  axlen of the dropped beat; valid with trans_dropped.
- outstanding  out  clog2(C_MAX_OUTSTANDING+1)  current outstanding count.
- err_underflow  out  1  sticky; set when trans_done arrives while outstanding=0.

Behaviour:
- Reset (axi4_arst=1 at a clock edge):
  - Decision queue is emptied; outstanding=0.
  - m_axi4_axvalid=0, master field registers=0, trans_dropped=0, drop_id=0, drop_len=0, err_underflow=0.
  - Mid-operation reset discards any pending master beat and any queued decisions.
  - dec_ready=1 and s_axi4_axready=0 from the first cycle after reset.
- Decision queue:
  - FIFO of 1-bit entries (1=drop). Push when (trans_accept|trans_drop) & dec_ready.
  - dec_ready = !full. Decisions offered while full are ignored; source must hold them.
  - No bypass: a decision pushed at cycle n can be used at cycle n+1 at the earliest.
  - Pointer wrap uses an extra MSB for full/empty.
- Head = the queue's head entry; head valid = queue not empty.
- slot_free = !m_axi4_axvalid | m_axi4_axready.
- s_axi4_axready, combinational:
  - head valid & head=drop & s_axi4_axvalid; OR
  - head valid & head=accept & s_axi4_axvalid & slot_free & (outstanding < C_MAX_OUTSTANDING).
- Accepted handshake at cycle n:
  - Pop the head.
  - Load master field registers; m_axi4_axvalid=1 at n+1.
  - Outstanding +1.
- Dropped handshake at cycle n:
  - Pop the head.
  - trans_dropped=1 at n+1, with drop_id and drop_len captured.
  - Master side and outstanding are unaffected.
- Master slice:
  - Fields are stable while m_axi4_axvalid=1 and m_axi4_axready=0.
  - m_axi4_axvalid clears after a handshake unless a new beat loads in the same cycle, giving back-to-back throughput of 1 beat/cycle.
- Outstanding counter:
  - Increment on accepted handshake; decrement on trans_done.
  - Both in the same cycle: unchanged.
  - trans_done at 0 with no increment: stays 0 and sets err_underflow.
  - Never exceeds C_MAX_OUTSTANDING.
- An s-side beat held without a head decision waits indefinitely. Inputs are assumed AXI-stable while valid&!ready.

Test Plan:
- Reset, then push accept, then s_axvalid with id=3, addr=0x1000, len=7 → s_axi4_axready pulses on the cycle after the push; next cycle m_axi4_axvalid=1 with id=3, addr=0x1000, len=7; with m_ready=1, trans_sent=1 and outstanding=1.
- Push drop, then s beat with id=5, len=3 → s_axi4_axready=1 same cycle; next cycle trans_dropped=1, drop_id=5, drop_len=3; m_axi4_axvalid stays 0; outstanding unchanged.
- Push 4 decisions at C_DEC_DEPTH=4 with no s traffic → dec_ready=0; 5th decision ignored; after one beat is consumed, dec_ready=1.
- C_MAX_OUTSTANDING=2: accept 3 beats with m_ready=1 and no trans_done → third s_axi4_axready held 0; one trans_done pulse releases it the next cycle; outstanding ends at 2.
- m_ready=0 for 5 cycles with 2 queued accepts → m fields stable, second beat stalled; raise m_ready → beats leave on consecutive cycles; simultaneous trans_done and new accept keep outstanding constant; trans_done at outstanding=0 sets err_underflow=1.
- Assert axi4_arst while m_axi4_axvalid=1 and queue holds 2 entries → next cycle m_axi4_axvalid=0, queue empty, outstanding=0, dec_ready=1.

Source files
------------

// File: rtl/axi4_ax_sender_q.sv
// -----------------------------------------------------------------------------
// axi4_ax_sender_q
//
// Address-channel sender for the RAB, usable for either AR or AW. A slave-side
// address beat is only taken once the translation logic has queued an accept
// or drop decision for it. Decisions are stored in order in a small FIFO and
// are matched one-to-one to slave-side beats.
//   - Accepted beats go into a registered master-side output slice.
//   - Dropped beats are reported through trans_dropped/drop_id/drop_len.
//   - An outstanding-transaction counter caps accepted-but-uncompleted
//     transactions at C_MAX_OUTSTANDING.
//
// Ports
//   axi4_aclk, axi4_arst        clock, synchronous active-high reset
//   trans_accept, trans_drop    decision inputs (drop wins if both are high)
//   dec_ready                   decision FIFO not full
//   trans_done                  one pulse per completed forwarded transaction
//   s_axi4_ax*                  slave-side address channel
//   m_axi4_ax*                  master-side address channel (registered)
//   trans_sent                  master-side handshake this cycle
//   trans_dropped, drop_id,     registered drop report for the
//   drop_len                    error-response generator
//   outstanding                 current outstanding count
//   err_underflow               sticky: trans_done seen with nothing outstanding
// -----------------------------------------------------------------------------
module axi4_ax_sender_q #(
  parameter int C_AXI_ID_WIDTH    = 4,
  parameter int C_AXI_USER_WIDTH  = 4,
  parameter int C_ADDR_WIDTH      = 32,
  parameter int C_DEC_DEPTH       = 4,
  parameter int C_MAX_OUTSTANDING = 8
) (
  input  logic                                   axi4_aclk,
  input  logic                                   axi4_arst,

  input  logic                                   trans_accept,
  input  logic                                   trans_drop,
  output logic                                   dec_ready,
  input  logic                                   trans_done,

  input  logic [C_AXI_ID_WIDTH-1:0]              s_axi4_axid,
  input  logic [C_ADDR_WIDTH-1:0]                s_axi4_axaddr,
  input  logic [7:0]                             s_axi4_axlen,
  input  logic [2:0]                             s_axi4_axsize,
  input  logic [1:0]                             s_axi4_axburst,
  input  logic                                   s_axi4_axlock,
  input  logic [2:0]                             s_axi4_axprot,
  input  logic [3:0]                             s_axi4_axcache,
  input  logic [C_AXI_USER_WIDTH-1:0]            s_axi4_axuser,
  input  logic                                   s_axi4_axvalid,
  output logic                                   s_axi4_axready,

  output logic [C_AXI_ID_WIDTH-1:0]              m_axi4_axid,
  output logic [C_ADDR_WIDTH-1:0]                m_axi4_axaddr,
  output logic [7:0]                             m_axi4_axlen,
  output logic [2:0]                             m_axi4_axsize,
  output logic [1:0]                             m_axi4_axburst,
  output logic                                   m_axi4_axlock,
  output logic [2:0]                             m_axi4_axprot,
  output logic [3:0]                             m_axi4_axcache,
  output logic [C_AXI_USER_WIDTH-1:0]            m_axi4_axuser,
  output logic                                   m_axi4_axvalid,
  input  logic                                   m_axi4_axready,

  output logic                                   trans_sent,
  output logic                                   trans_dropped,
  output logic [C_AXI_ID_WIDTH-1:0]              drop_id,
  output logic [7:0]                             drop_len,
  output logic [$clog2(C_MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                   err_underflow
);

  localparam int PTR_W = $clog2(C_DEC_DEPTH);
  localparam int OUT_W = $clog2(C_MAX_OUTSTANDING + 1);

  localparam logic [PTR_W:0]   PTR_ONE = (PTR_W + 1)'(1'b1);
  localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1'b1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(C_MAX_OUTSTANDING);

  // Decision FIFO: one bit per entry, 1 = drop. Pointers carry an extra MSB
  // so that full and empty can be told apart when the index bits match.
  logic [C_DEC_DEPTH-1:0] dec_mem_r;
  logic [PTR_W:0]         wr_ptr_r;
  logic [PTR_W:0]         rd_ptr_r;

  logic full_s;
  logic empty_s;
  logic push_s;
  logic head_drop_s;
  logic slot_free_s;
  logic below_max_s;
  logic s_ready_s;
  logic acc_hs_s;
  logic drop_hs_s;
  logic pop_s;

  // Queue status, handshake qualification and the combinational outputs.
  always_comb begin
    empty_s     = (wr_ptr_r == rd_ptr_r);
    full_s      = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                  (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    push_s      = (trans_accept | trans_drop) & ~full_s;
    head_drop_s = dec_mem_r[rd_ptr_r[PTR_W-1:0]];
    slot_free_s = ~m_axi4_axvalid | m_axi4_axready;
    below_max_s = (outstanding < OUT_MAX);

    // A drop never reaches the master side, so it needs neither a free slot
    // nor outstanding credit; an accept needs both.
    if (empty_s) begin
      s_ready_s = 1'b0;
    end else if (head_drop_s) begin
      s_ready_s = s_axi4_axvalid;
    end else begin
      s_ready_s = s_axi4_axvalid & slot_free_s & below_max_s;
    end

    acc_hs_s  = s_ready_s & s_axi4_axvalid & ~head_drop_s;
    drop_hs_s = s_ready_s & s_axi4_axvalid & head_drop_s;
    pop_s     = acc_hs_s | drop_hs_s;

    dec_ready      = ~full_s;
    s_axi4_axready = s_ready_s;
    trans_sent     = m_axi4_axvalid & m_axi4_axready;
  end

  // Decision FIFO storage and pointers; no bypass from push to head.
  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      dec_mem_r <= {C_DEC_DEPTH{1'b0}};
      wr_ptr_r  <= {(PTR_W + 1){1'b0}};
      rd_ptr_r  <= {(PTR_W + 1){1'b0}};
    end else begin
      if (push_s) begin
        dec_mem_r[wr_ptr_r[PTR_W-1:0]] <= trans_drop;
        wr_ptr_r                       <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Master output slice: load on accepted beat, otherwise hold until taken.
  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      m_axi4_axvalid <= 1'b0;
      m_axi4_axid    <= {C_AXI_ID_WIDTH{1'b0}};
      m_axi4_axaddr  <= {C_ADDR_WIDTH{1'b0}};
      m_axi4_axlen   <= 8'h00;
      m_axi4_axsize  <= 3'b000;
      m_axi4_axburst <= 2'b00;
      m_axi4_axlock  <= 1'b0;
      m_axi4_axprot  <= 3'b000;
      m_axi4_axcache <= 4'h0;
      m_axi4_axuser  <= {C_AXI_USER_WIDTH{1'b0}};
    end else if (acc_hs_s) begin
      // acc_hs_s already implies the slot is free, so overwriting is safe.
      m_axi4_axvalid <= 1'b1;
      m_axi4_axid    <= s_axi4_axid;
      m_axi4_axaddr  <= s_axi4_axaddr;
      m_axi4_axlen   <= s_axi4_axlen;
      m_axi4_axsize  <= s_axi4_axsize;
      m_axi4_axburst <= s_axi4_axburst;
      m_axi4_axlock  <= s_axi4_axlock;
      m_axi4_axprot  <= s_axi4_axprot;
      m_axi4_axcache <= s_axi4_axcache;
      m_axi4_axuser  <= s_axi4_axuser;
    end else if (m_axi4_axready) begin
      m_axi4_axvalid <= 1'b0;
    end else begin
      m_axi4_axvalid <= m_axi4_axvalid;
    end
  end

  // Drop report toward the error-response generator.
  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      trans_dropped <= 1'b0;
      drop_id       <= {C_AXI_ID_WIDTH{1'b0}};
      drop_len      <= 8'h00;
    end else begin
      trans_dropped <= drop_hs_s;
      if (drop_hs_s) begin
        drop_id  <= s_axi4_axid;
        drop_len <= s_axi4_axlen;
      end else begin
        drop_id  <= drop_id;
        drop_len <= drop_len;
      end
    end
  end

  // Outstanding counter with sticky underflow flag.
  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      outstanding   <= {OUT_W{1'b0}};
      err_underflow <= 1'b0;
    end else begin
      case ({acc_hs_s, trans_done})
        2'b10: begin
          outstanding <= outstanding + OUT_ONE;
        end
        2'b01: begin
          if (outstanding == {OUT_W{1'b0}}) begin
            err_underflow <= 1'b1;
          end else begin
            outstanding <= outstanding - OUT_ONE;
          end
        end
        default: begin
          // Idle, or increment and decrement cancelling out.
          outstanding <= outstanding;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_ax_sender_q.sv
// Directed bench for axi4_ax_sender_q (queue depth 4, outstanding limit 2).
module tb_axi4_ax_sender_q;

  logic        clk = 1'b0;
  logic        rst;
  logic        trans_accept, trans_drop, dec_ready, trans_done;
  logic [3:0]  s_id;
  logic [31:0] s_addr;
  logic [7:0]  s_len;
  logic        s_valid, s_ready;
  logic [3:0]  m_id;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic [2:0]  m_size, m_prot;
  logic [1:0]  m_burst;
  logic        m_lock;
  logic [3:0]  m_cache, m_user;
  logic        m_valid, m_ready;
  logic        trans_sent, trans_dropped;
  logic [3:0]  drop_id;
  logic [7:0]  drop_len;
  logic [1:0]  outstanding;
  logic        err_underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi4_ax_sender_q #(
    .C_AXI_ID_WIDTH(4), .C_AXI_USER_WIDTH(4), .C_ADDR_WIDTH(32),
    .C_DEC_DEPTH(4), .C_MAX_OUTSTANDING(2)
  ) dut (
    .axi4_aclk(clk), .axi4_arst(rst),
    .trans_accept(trans_accept), .trans_drop(trans_drop),
    .dec_ready(dec_ready), .trans_done(trans_done),
    .s_axi4_axid(s_id), .s_axi4_axaddr(s_addr), .s_axi4_axlen(s_len),
    .s_axi4_axsize(3'd2), .s_axi4_axburst(2'd1), .s_axi4_axlock(1'b0),
    .s_axi4_axprot(3'd0), .s_axi4_axcache(4'd0), .s_axi4_axuser(4'd0),
    .s_axi4_axvalid(s_valid), .s_axi4_axready(s_ready),
    .m_axi4_axid(m_id), .m_axi4_axaddr(m_addr), .m_axi4_axlen(m_len),
    .m_axi4_axsize(m_size), .m_axi4_axburst(m_burst), .m_axi4_axlock(m_lock),
    .m_axi4_axprot(m_prot), .m_axi4_axcache(m_cache), .m_axi4_axuser(m_user),
    .m_axi4_axvalid(m_valid), .m_axi4_axready(m_ready),
    .trans_sent(trans_sent), .trans_dropped(trans_dropped),
    .drop_id(drop_id), .drop_len(drop_len),
    .outstanding(outstanding), .err_underflow(err_underflow)
  );

  // Advance past the next rising edge; inputs may then be changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; trans_accept = 1'b0; trans_drop = 1'b0; trans_done = 1'b0;
    s_valid = 1'b0; s_id = 4'd0; s_addr = 32'd0; s_len = 8'd0; m_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    s_valid = 1'b1;
    settle();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mvalid got=%0b exp=0", m_valid); end
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL rst_dec_ready got=%0b exp=1", dec_ready); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got=%0b exp=0", s_ready); end
    checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL rst_outstanding got=%0d exp=0", outstanding); end
    checks++; if ({trans_dropped, drop_id, drop_len, err_underflow} !== 14'd0) begin
      errors++; $display("FAIL rst_drop_err got=%0b/%0h/%0h/%0b exp=0", trans_dropped, drop_id, drop_len, err_underflow); end
    checks++; if ({m_id, m_addr, m_len} !== 44'd0) begin errors++; $display("FAIL rst_mfields got=%0h/%0h/%0h exp=0", m_id, m_addr, m_len); end
    tick();
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL wait_no_decision got=%0b exp=0", s_ready); end
    s_valid = 1'b0;
  endtask

  task automatic test_accept();
    trans_accept = 1'b1;
    tick();
    trans_accept = 1'b0;
    s_valid = 1'b1; s_id = 4'd3; s_addr = 32'h0000_1000; s_len = 8'd7;
    settle();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL acc_s_ready got=%0b exp=1", s_ready); end
    tick();
    s_valid = 1'b0;
    settle();
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL acc_s_ready_pulse got=%0b exp=0", s_ready); end
    checks++; if (m_valid !== 1'b1 || m_id !== 4'd3 || m_addr !== 32'h1000 || m_len !== 8'd7) begin
      errors++; $display("FAIL acc_mbeat got=%0b/%0h/%0h/%0h exp=1/3/1000/7", m_valid, m_id, m_addr, m_len); end
    checks++; if (outstanding !== 2'd1) begin errors++; $display("FAIL acc_outstanding got=%0d exp=1", outstanding); end
    m_ready = 1'b1;
    settle();
    checks++; if (trans_sent !== 1'b1) begin errors++; $display("FAIL acc_trans_sent got=%0b exp=1", trans_sent); end
    tick();
    m_ready = 1'b0;
    settle();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL acc_mvalid_clear got=%0b exp=0", m_valid); end
    trans_done = 1'b1;
    tick();
    trans_done = 1'b0;
    checks++; if (outstanding !== 2'd0 || err_underflow !== 1'b0) begin
      errors++; $display("FAIL acc_done got=%0d/%0b exp=0/0", outstanding, err_underflow); end
  endtask

  task automatic test_drop();
    trans_drop = 1'b1;
    tick();
    trans_drop = 1'b0;
    s_valid = 1'b1; s_id = 4'd5; s_addr = 32'h0000_4000; s_len = 8'd3;
    settle();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL drop_s_ready got=%0b exp=1", s_ready); end
    tick();
    s_valid = 1'b0;
    checks++; if (trans_dropped !== 1'b1 || drop_id !== 4'd5 || drop_len !== 8'd3) begin
      errors++; $display("FAIL drop_report got=%0b/%0h/%0h exp=1/5/3", trans_dropped, drop_id, drop_len); end
    checks++; if (m_valid !== 1'b0 || outstanding !== 2'd0) begin
      errors++; $display("FAIL drop_master got=%0b/%0d exp=0/0", m_valid, outstanding); end
    tick();
    checks++; if (trans_dropped !== 1'b0) begin errors++; $display("FAIL drop_pulse got=%0b exp=0", trans_dropped); end
    // Both decisions high: the drop takes precedence.
    trans_accept = 1'b1; trans_drop = 1'b1;
    tick();
    trans_accept = 1'b0; trans_drop = 1'b0;
    s_valid = 1'b1; s_id = 4'd6; s_len = 8'd9;
    tick();
    s_valid = 1'b0;
    checks++; if (trans_dropped !== 1'b1 || drop_id !== 4'd6 || drop_len !== 8'd9 || m_valid !== 1'b0) begin
      errors++; $display("FAIL drop_wins got=%0b/%0h/%0h/%0b exp=1/6/9/0", trans_dropped, drop_id, drop_len, m_valid); end
    tick();
  endtask

  task automatic test_queue_full();
    trans_accept = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL full_dec_ready got=%0b exp=0", dec_ready); end
    tick();  // fifth decision offered while full: must be ignored
    trans_accept = 1'b0;
    settle();
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL full_hold got=%0b exp=0", dec_ready); end
    s_valid = 1'b1; s_id = 4'd1; m_ready = 1'b1;
    tick();
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL full_release got=%0b exp=1", dec_ready); end
    // Drain three more with a completion every cycle: count holds at 1.
    trans_done = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    trans_done = 1'b0;
    settle();
    checks++; if (outstanding !== 2'd1) begin errors++; $display("FAIL full_inc_dec got=%0d exp=1", outstanding); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_fifth_ignored got=%0b exp=0", s_ready); end
    s_valid = 1'b0;
    tick();
    m_ready = 1'b0;
    trans_done = 1'b1;
    tick();
    trans_done = 1'b0;
    checks++; if (outstanding !== 2'd0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL full_cleanup got=%0d/%0b exp=0/0", outstanding, m_valid); end
  endtask

  task automatic test_max_outstanding();
    trans_accept = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    trans_accept = 1'b0;
    m_ready = 1'b1; s_valid = 1'b1; s_id = 4'd2;
    tick(); tick();
    settle();
    checks++; if (outstanding !== 2'd2 || s_ready !== 1'b0) begin
      errors++; $display("FAIL max_block got=%0d/%0b exp=2/0", outstanding, s_ready); end
    tick();
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL max_hold got=%0b exp=0", s_ready); end
    trans_done = 1'b1;
    tick();
    trans_done = 1'b0;
    settle();
    checks++; if (s_ready !== 1'b1 || outstanding !== 2'd1) begin
      errors++; $display("FAIL max_release got=%0b/%0d exp=1/1", s_ready, outstanding); end
    tick();
    s_valid = 1'b0;
    checks++; if (outstanding !== 2'd2) begin errors++; $display("FAIL max_final got=%0d exp=2", outstanding); end
    tick();
    trans_done = 1'b1;
    tick(); tick();
    trans_done = 1'b0; m_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    trans_accept = 1'b1;
    tick(); tick();
    trans_accept = 1'b0;
    s_valid = 1'b1; s_id = 4'hA; s_addr = 32'h0000_2000; s_len = 8'd1;
    tick();
    s_id = 4'hB; s_addr = 32'h0000_3000; s_len = 8'd2;
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++; if (m_valid !== 1'b1 || m_id !== 4'hA || m_addr !== 32'h2000 || m_len !== 8'd1 || s_ready !== 1'b0) begin
        errors++; $display("FAIL b2b_stall[%0d] got=%0b/%0h/%0h/%0h/%0b exp=1/a/2000/1/0", i, m_valid, m_id, m_addr, m_len, s_ready); end
      tick();
    end
    m_ready = 1'b1;
    settle();
    checks++; if (trans_sent !== 1'b1 || s_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first got=%0b/%0b exp=1/1", trans_sent, s_ready); end
    tick();
    s_valid = 1'b0;
    settle();
    checks++; if (m_valid !== 1'b1 || m_id !== 4'hB || m_addr !== 32'h3000 || trans_sent !== 1'b1) begin
      errors++; $display("FAIL b2b_second got=%0b/%0h/%0h/%0b exp=1/b/3000/1", m_valid, m_id, m_addr, trans_sent); end
    tick();
    checks++; if (m_valid !== 1'b0 || outstanding !== 2'd2) begin
      errors++; $display("FAIL b2b_drain got=%0b/%0d exp=0/2", m_valid, outstanding); end
    trans_done = 1'b1; trans_accept = 1'b1;
    tick();  // 2 -> 1, decision queued
    trans_accept = 1'b0; s_valid = 1'b1; s_id = 4'hC;
    tick();  // accept and completion together
    s_valid = 1'b0;
    checks++; if (outstanding !== 2'd1) begin errors++; $display("FAIL b2b_simul got=%0d exp=1", outstanding); end
    tick();  // 1 -> 0
    checks++; if (outstanding !== 2'd0 || err_underflow !== 1'b0) begin
      errors++; $display("FAIL b2b_to_zero got=%0d/%0b exp=0/0", outstanding, err_underflow); end
    tick();  // completion with nothing outstanding
    trans_done = 1'b0;
    checks++; if (outstanding !== 2'd0 || err_underflow !== 1'b1) begin
      errors++; $display("FAIL underflow got=%0d/%0b exp=0/1", outstanding, err_underflow); end
    tick();
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky got=%0b exp=1", err_underflow); end
    m_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    trans_accept = 1'b1;
    tick(); tick(); tick();
    trans_accept = 1'b0;
    s_valid = 1'b1; s_id = 4'h7; s_addr = 32'h0000_5000;
    tick();
    s_valid = 1'b0;
    checks++; if (m_valid !== 1'b1 || outstanding !== 2'd1) begin
      errors++; $display("FAIL rmid_setup got=%0b/%0d exp=1/1", m_valid, outstanding); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_valid = 1'b1;
    settle();
    checks++; if (m_valid !== 1'b0 || m_id !== 4'd0 || outstanding !== 2'd0 || err_underflow !== 1'b0) begin
      errors++; $display("FAIL rmid_state got=%0b/%0h/%0d/%0b exp=0/0/0/0", m_valid, m_id, outstanding, err_underflow); end
    checks++; if (dec_ready !== 1'b1 || s_ready !== 1'b0) begin
      errors++; $display("FAIL rmid_queue got=%0b/%0b exp=1/0", dec_ready, s_ready); end
    s_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_accept();
    test_drop();
    test_queue_full();
    test_max_outstanding();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
